// File: rtl/cpu_state_scanner_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_state_scanner_if : tagged valid/ready word stream (scanner -> sink)  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface cpu_state_scanner_if;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_tag;
  logic [31:0] out_data;
  logic        out_last;

  modport master (
    output out_valid,
    output out_tag,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_tag,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/cpu_state_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_state_scanner : snapshots PC/INST, then walks GPRs and a data-memory |
// | window through the CPU test ports, emitting tagged words on a stream.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module cpu_state_scanner #(
  parameter int unsigned MEM_WORDS = 32,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            start,
  input  wire logic [31:0]     cpu_pc,
  input  wire logic [31:0]     cpu_inst,
  output logic      [4:0]      rf_addr,
  input  wire logic [31:0]     rf_data,
  output logic      [31:0]     mem_addr,
  input  wire logic [31:0]     mem_data,
  cpu_state_scanner_if.master  out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned N_WORDS   = 34 + MEM_WORDS;
  localparam logic [6:0]  LAST_IDX  = 7'(N_WORDS - 1);
  localparam logic [6:0]  GPR_FIRST = 7'd2;
  localparam logic [6:0]  MEM_FIRST = 7'd34;
  localparam logic [7:0]  TAG_PC    = 8'h80;
  localparam logic [7:0]  TAG_INST  = 8'h81;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_SAMPLE = 2'd2,
    S_SEND   = 2'd3
  } state_t;

  state_t      state_q,     state_d;
  logic [6:0]  idx_q,       idx_d;
  logic [31:0] pc_snap_q,   pc_snap_d;
  logic [31:0] inst_snap_q, inst_snap_d;
  logic [4:0]  rf_addr_q,   rf_addr_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_tag_q,   out_tag_d;
  logic [31:0] out_data_q,  out_data_d;
  logic        out_last_q,  out_last_d;
  logic        busy_q,      busy_d;
  logic        done_q,      done_d;

  logic        w_is_pc;
  logic        w_is_inst;
  logic        w_is_gpr;
  logic        w_is_mem;
  logic        w_is_last;
  logic [4:0]  w_gpr_n;
  logic [5:0]  w_mem_k;
  logic [31:0] w_mem_byte_addr;

  // Low-bit arithmetic wraps correctly over the legal index ranges.
  assign w_is_pc         = (idx_q == 7'd0);
  assign w_is_inst       = (idx_q == 7'd1);
  assign w_is_gpr        = (idx_q >= GPR_FIRST) && (idx_q < MEM_FIRST);
  assign w_is_mem        = (idx_q >= MEM_FIRST);
  assign w_is_last       = (idx_q == LAST_IDX);
  assign w_gpr_n         = idx_q[4:0] - 5'd2;
  assign w_mem_k         = idx_q[5:0] - 6'd34;
  assign w_mem_byte_addr = MEM_BASE + {24'd0, w_mem_k, 2'b00};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pc_snap_d   = pc_snap_q;
    inst_snap_d = inst_snap_q;
    rf_addr_d   = rf_addr_q;
    mem_addr_d  = mem_addr_q;
    out_valid_d = out_valid_q;
    out_tag_d   = out_tag_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The done cycle is already IDLE, but a start there must not re-arm.
        if (start && !done_q) begin
          idx_d       = 7'd0;
          pc_snap_d   = cpu_pc;
          inst_snap_d = cpu_inst;
          busy_d      = 1'b1;
          state_d     = S_ADDR;
        end
      end

      S_ADDR: begin
        if (w_is_gpr) begin
          rf_addr_d = w_gpr_n;
        end
        if (w_is_mem) begin
          mem_addr_d = w_mem_byte_addr;
        end
        state_d = S_SAMPLE;
      end

      S_SAMPLE: begin
        if (w_is_pc) begin
          out_tag_d  = TAG_PC;
          out_data_d = pc_snap_q;
        end else if (w_is_inst) begin
          out_tag_d  = TAG_INST;
          out_data_d = inst_snap_q;
        end else if (w_is_gpr) begin
          out_tag_d  = {3'b000, w_gpr_n};
          out_data_d = rf_data;
        end else begin
          out_tag_d  = {2'b01, w_mem_k};
          out_data_d = mem_data;
        end
        out_last_d  = w_is_last;
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end

      S_SEND: begin
        if (out.out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (w_is_last) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = S_ADDR;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 7'd0;
      pc_snap_q   <= 32'd0;
      inst_snap_q <= 32'd0;
      rf_addr_q   <= 5'd0;
      mem_addr_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_tag_q   <= 8'd0;
      out_data_q  <= 32'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pc_snap_q   <= pc_snap_d;
      inst_snap_q <= inst_snap_d;
      rf_addr_q   <= rf_addr_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf_addr       = rf_addr_q;
  assign mem_addr      = mem_addr_q;
  assign out.out_valid = out_valid_q;
  assign out.out_tag   = out_tag_q;
  assign out.out_data  = out_data_q;
  assign out.out_last  = out_last_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
`default_nettype wire
